bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Converts one WIDTH-bit unsigned value per transaction into DIGITS packed BCD digits.
//   Valid/ready handshake on both sides; sits between binary datapaths and 7-seg/display drivers.
//   Successor to the combinational 5-bit two-digit BCD decoder: any width, any digit count, overflow flag.
// PARAMETERS
//   WIDTH   5   binary input width in bits (>=1)
//   DIGITS  2   number of BCD output digits (>=1); 4*DIGITS output bits
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous, active-low reset
//   in_valid   in   1          in_bin holds a value to convert
//   in_ready   out  1          converter can accept (state IDLE)
//   in_bin     in   WIDTH      unsigned binary operand
//   out_valid  out  1          out_bcd/out_ovf hold a finished result
//   out_ready  in   1          consumer accepts result
//   out_bcd    out  4*DIGITS   packed BCD, digit 0 (units) in [3:0]
//   out_ovf    out  1          in_bin >= 10**DIGITS; out_bcd = in_bin mod 10**DIGITS
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_ovf=0, counter=0.
//   States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: in_ready=1. On edge with in_valid=1: load shift reg <= in_bin, BCD acc <= 0, ovf <= 0,
//     cnt <= 0, go SHIFT. in_ready=0 from the next cycle.
//   SHIFT: one step per clock: every BCD digit >=5 gets +3, then {acc,shreg} shifts left 1.
//     Bit leaving top digit is discarded; if it is 1, ovf <= 1 (sticky for this transaction).
//     After the WIDTH-th step (cnt==WIDTH-1) go DONE; out_bcd/out_ovf registered that same edge.
//   DONE: out_valid=1; out_bcd, out_ovf stable until handshake. On edge with out_ready=1:
//     out_valid <= 0, go IDLE. out_bcd/out_ovf keep last value after handshake.
//   Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
//   Throughput: one result per WIDTH+2 cycles with out_ready held high.
//   in_valid while in SHIFT/DONE is ignored (in_ready=0); in_bin sampled only on accept edge.
//   out_ready while out_valid=0 has no effect.
//   Counter width $clog2(WIDTH+1); WIDTH=1 supported (single SHIFT cycle).
//   Reset asserted mid-conversion aborts it; no partial result is presented.
//   No combinational path from in_valid/out_ready to in_ready/out_valid.
// TESTING
//   1. WIDTH=5,DIGITS=2: sweep in_bin 0..31, out_ready=1 -> out_bcd==tens:units
//      (e.g. 31 -> 8'h31, 9 -> 8'h09), out_ovf=0, out_valid exactly 5 cycles after accept.
//   2. WIDTH=8,DIGITS=2: in_bin=255 -> out_bcd=8'h55, out_ovf=1;
//      in_bin=99 -> 8'h99, ovf=0; in_bin=100 -> 8'h00, ovf=1.
//   3. WIDTH=8,DIGITS=3: exhaustive 0..255 vs reference model; 255 -> 12'h255, ovf=0.
//   4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable,
//      in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
//   5. Reset mid-op: rst_n low 3 cycles into SHIFT -> immediately in_ready=1, out_valid=0,
//      out_bcd=0; next accepted value 42 converts to 8'h42 correctly.
//   6. Back-to-back: in_valid and out_ready held high, values 7,18,30 -> results in order,
//      spaced WIDTH+2 cycles.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one WIDTH-step conversion per
// transaction with valid/ready on both sides and an overflow flag for values >= 10**DIGITS.
module bin2bcd_seq #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready/out_valid are decoded from the state register only, never from inputs.

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_shift;
  logic [BW-1:0]    acc_q, acc_d, acc_adj, acc_shift;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             rovf_q, rovf_d;
  logic             carry;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    // The bit leaving the top digit is the mod-10**DIGITS carry; it only flags overflow.
    {carry, acc_shift, sh_shift} = {acc_adj, sh_q, 1'b0};
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    rovf_d  = rovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = in_bin;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = sh_shift;
        acc_d = acc_shift;
        ovf_d = ovf_q | carry;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = acc_shift;
          rovf_d  = ovf_q | carry;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      rovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      rovf_q  <= rovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = bcd_q;
  assign out_ovf   = rovf_q;

endmodule
